// File: rtl/sig_dump_unit.sv
// sig_dump_unit: shadows signature stores from the core, then streams them out on tohost or timeout.
module sig_dump_unit #(
  parameter logic [31:0] SIG_BASE = 32'h0000_1000,
  parameter int SIG_WORDS = 8,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1FF0,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IW = SIG_WORDS > 1 ? $clog2(SIG_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dmem_we,
  input  logic [31:0]   dmem_addr,
  input  logic [31:0]   dmem_wdata,
  input  logic [3:0]    dmem_wstrb,
  output logic          sig_valid,
  input  logic          sig_ready,
  output logic [31:0]   sig_data,
  output logic [IW-1:0] sig_idx,
  output logic          sig_last,
  output logic          halted,
  output logic          timed_out,
  output logic [31:0]   exit_code,
  output logic          done
);
  typedef enum logic [1:0] {RUN, DUMP, DONE} state_t;
  state_t state, state_nxt;
  logic [31:0] shadow [SIG_WORDS];
  logic [31:0] cnt;
  logic [29:0] woff;
  logic hit, tohost, tmo, xfer, unused;
  assign unused = ^dmem_addr[1:0];
  assign woff = dmem_addr[31:2] - SIG_BASE[31:2];
  assign hit = dmem_we && (woff < 30'(SIG_WORDS));
  assign tohost = dmem_we && dmem_addr[31:2] == TOHOST_ADDR[31:2] && dmem_wstrb == 4'hF && |dmem_wdata;
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));
  assign xfer = sig_valid && sig_ready;
  assign sig_data = shadow[sig_idx];
  always_comb begin
    state_nxt = state;
    if (state == RUN && (tohost || tmo)) state_nxt = DUMP;
    if (state == DUMP && xfer && sig_last) state_nxt = DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SIG_WORDS; i++) shadow[i] <= '0;
      cnt <= '0;
      sig_idx <= '0;
      exit_code <= '0;
      sig_valid <= 1'b0;
      sig_last <= 1'b0;
      halted <= 1'b0;
      timed_out <= 1'b0;
      done <= 1'b0;
    end else if (state == RUN) begin
      cnt <= cnt + 32'd1;
      if (hit)
        for (int b = 0; b < 4; b++)
          if (dmem_wstrb[b]) shadow[woff[IW-1:0]][8*b +: 8] <= dmem_wdata[8*b +: 8];
      if (tohost) begin
        exit_code <= dmem_wdata;
        halted <= 1'b1;
      end else if (tmo) timed_out <= 1'b1;
      if (tohost || tmo) begin
        sig_valid <= 1'b1;
        sig_idx <= '0;
        sig_last <= SIG_WORDS == 1;
      end
    end else if (state == DUMP && xfer) begin
      if (sig_last) begin
        sig_valid <= 1'b0;
        sig_last <= 1'b0;
        done <= 1'b1;
      end else begin
        sig_idx <= sig_idx + 1'b1;
        sig_last <= sig_idx == IW'(SIG_WORDS - 2);
      end
    end
  end
endmodule

// File: tb/tb_sig_dump_unit.sv
// tb_sig_dump_unit: directed and randomized checks of sig_dump_unit against a cycle-level behavioural model.
module tb_sig_dump_unit;
  localparam int N = 8;
  localparam int T = 16;
  localparam logic [31:0] TH = 32'h0000_1FF0;
  logic clk = 0, rst_n = 0, dmem_we = 0, sig_ready = 0;
  logic [31:0] dmem_addr = 0, dmem_wdata = 0;
  logic [3:0] dmem_wstrb = 0;
  logic sig_valid, sig_last, halted, timed_out, done;
  logic [31:0] sig_data, exit_code;
  logic [2:0] sig_idx;
  int total = 0, bad = 0;
  logic [31:0] got[$];
  logic [31:0] wr[N];
  always #5 clk = ~clk;
  sig_dump_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .sig_valid(sig_valid),
    .sig_ready(sig_ready), .sig_data(sig_data), .sig_idx(sig_idx), .sig_last(sig_last),
    .halted(halted), .timed_out(timed_out), .exit_code(exit_code), .done(done)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, e, $time);
    end
  endtask
  // Model: mode 0=run 1=dump 2=done; m_cnt counts run cycles since reset
  int m_mode = 0, m_cnt = 0, m_idx = 0;
  logic [31:0] m_sh[N], m_exit = 0, m_diff;
  logic m_halt = 0, m_tout = 0, m_done = 0, m_th, started = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_idx = 0; m_exit = 0;
      m_halt = 0; m_tout = 0; m_done = 0; started = 1;
      for (int i = 0; i < N; i++) m_sh[i] = 0;
    end else if (m_mode == 0) begin
      m_diff = (dmem_addr >> 2) - (32'h1000 >> 2);
      if (dmem_we && m_diff < N)
        for (int b = 0; b < 4; b++)
          if (dmem_wstrb[b]) m_sh[m_diff][8*b +: 8] = dmem_wdata[8*b +: 8];
      m_th = dmem_we && (dmem_addr >> 2) == (TH >> 2) && dmem_wstrb == 4'hF && dmem_wdata != 0;
      if (m_th) begin
        m_mode = 1; m_idx = 0; m_exit = dmem_wdata; m_halt = 1;
      end else if (m_cnt == T - 1) begin
        m_mode = 1; m_idx = 0; m_tout = 1;
      end
      m_cnt++;
    end else if (m_mode == 1 && sig_ready) begin
      if (m_idx == N - 1) begin m_mode = 2; m_done = 1; end
      else m_idx++;
    end
  end
  always @(negedge clk) if (started) begin
    chk("valid", sig_valid, m_mode == 1);
    chk("halted", halted, m_halt);
    chk("timed_out", timed_out, m_tout);
    chk("exit_code", exit_code, m_exit);
    chk("done", done, m_done);
    if (m_mode == 1) begin
      chk("idx", sig_idx, m_idx);
      chk("data", sig_data, m_sh[m_idx]);
      chk("last", sig_last, m_idx == N - 1);
    end else chk("last_idle", sig_last, 0);
    if (rst_n && sig_valid && sig_ready) got.push_back(sig_data);
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dmem_we = 1; dmem_addr = a; dmem_wdata = d; dmem_wstrb = s;
    tick;
    dmem_we = 0;
  endtask
  task automatic do_reset;
    rst_n = 0; dmem_we = 0; sig_ready = 0;
    tick;
    rst_n = 1;
    got.delete();
  endtask
  task automatic wait_done(input bit rnd);
    int n = 0;
    while (!done && n < 200) begin
      sig_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick;
      n++;
    end
    sig_ready = 0;
    chk("done_reached", done, 1);
    chk("xfer_count", got.size(), N);
  endtask
  initial begin
    int n;
    logic [31:0] d;
    logic [2:0] ix;
    // byte-strobe capture
    do_reset;
    st(32'h1004, 32'hDEADBEEF, 4'hF);
    st(32'h1004, 32'h000000AA, 4'h1);
    st(TH, 1, 4'hF);
    wait_done(0);
    if (got.size() == N)
      for (int i = 0; i < N; i++) chk("strobe_word", got[i], i == 1 ? 32'hDEADBEAA : 0);
    // normal dump with ready high
    do_reset;
    for (int i = 0; i < N; i++) st(32'h1000 + 4 * i, 32'h100 + i, 4'hF);
    sig_ready = 1;
    st(TH, 1, 4'hF);
    chk("trig_halted", halted, 1);
    chk("trig_valid", sig_valid, 1);
    chk("trig_idx", sig_idx, 0);
    repeat (7) tick;
    chk("done_early", done, 0);
    tick;
    chk("done_n8", done, 1);
    chk("exit_one", exit_code, 1);
    wait_done(0);
    if (got.size() == N)
      for (int i = 0; i < N; i++) chk("normal_word", got[i], 32'h100 + i);
    // backpressure
    do_reset;
    for (int i = 0; i < N; i++) begin
      wr[i] = $urandom;
      st(32'h1000 + 4 * i, wr[i], 4'hF);
    end
    sig_ready = 1;
    st(TH, 7, 4'hF);
    tick;
    tick;
    sig_ready = 0;
    d = sig_data;
    ix = sig_idx;
    chk("stall_idx2", ix, 2);
    repeat (3) begin
      tick;
      chk("stall_data", sig_data, d);
      chk("stall_idx", sig_idx, ix);
    end
    wait_done(1);
    if (got.size() == N)
      for (int i = 0; i < N; i++) chk("bp_word", got[i], wr[i]);
    // ignored writes
    do_reset;
    st(TH, 0, 4'hF);
    st(TH, 32'hFFFFFFFF, 4'h3);
    st(32'h1020, 32'h12345678, 4'hF);
    chk("ign_halted", halted, 0);
    chk("ign_valid", sig_valid, 0);
    st(TH, 2, 4'hF);
    st(32'h1000, 32'h55, 4'hF);
    wait_done(0);
    chk("ign_exit", exit_code, 2);
    if (got.size() == N)
      for (int i = 0; i < N; i++) chk("ign_word", got[i], 0);
    // timeout
    do_reset;
    n = 0;
    while (!sig_valid && n < 40) begin tick; n++; end
    chk("to_rise", n, T);
    chk("to_flag", timed_out, 1);
    chk("to_halted", halted, 0);
    chk("to_exit", exit_code, 0);
    wait_done(1);
    do_reset;
    repeat (T - 1) tick;
    st(TH, 5, 4'hF);
    chk("race_halted", halted, 1);
    chk("race_tout", timed_out, 0);
    chk("race_exit", exit_code, 5);
    wait_done(1);
    // reset mid-dump
    do_reset;
    for (int i = 0; i < N; i++) st(32'h1000 + 4 * i, 32'hA0 + i, 4'hF);
    sig_ready = 1;
    st(TH, 3, 4'hF);
    repeat (3) tick;
    chk("mid_idx", sig_idx, 3);
    rst_n = 0;
    tick;
    chk("rst_valid", sig_valid, 0);
    chk("rst_idx", sig_idx, 0);
    chk("rst_last", sig_last, 0);
    chk("rst_halted", halted, 0);
    chk("rst_exit", exit_code, 0);
    rst_n = 1;
    got.delete();
    st(TH, 9, 4'hF);
    wait_done(0);
    if (got.size() == N)
      for (int i = 0; i < N; i++) chk("rst_word", got[i], 0);
    // randomized runs
    repeat (30) begin
      do_reset;
      n = $urandom_range(0, 20);
      repeat (n) begin
        sig_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 5) == 0)
          st(TH, $urandom_range(0, 1) ? 32'h0 : $urandom, $urandom_range(0, 1) ? 4'hF : 4'h3);
        else
          st(32'h1000 + 4 * $urandom_range(0, 9) + $urandom_range(0, 3), $urandom, 4'($urandom));
      end
      wait_done(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sig_dump_unit.md
# sig_dump_unit

Memory-mapped signature capture and export unit for the single-cycle RV32I core. It snoops the core's data-memory write port and keeps a shadow copy of the signature region. It detects the program's end-of-test write to a `tohost` word, or a cycle timeout. It then streams the captured signature words out over a valid/ready interface, so a bench or host link receives the results without reaching into `data_memory` internals.

## Interface
Parameters:
- `SIG_BASE`, 32'h0000_1000, byte address of signature word 0 (word aligned).
- `SIG_WORDS`, 8, number of 32-bit signature words shadowed and exported (≥1).
- `TOHOST_ADDR`, 32'h0000_1FF0, byte address of the end-of-test word (word aligned, outside the signature region).
- `TIMEOUT_CYCLES`, 4096, cycles in RUN before a forced dump; 0 disables the timeout.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `dmem_we` in 1: core data-memory write enable.
- `dmem_addr` in 32: core data-memory byte address.
- `dmem_wdata` in 32: core store data, lane-aligned.
- `dmem_wstrb` in 4: byte enables; bit i qualifies `dmem_wdata[8i+7:8i]`.
- `sig_valid` out 1: signature word available.
- `sig_ready` in 1: consumer accepts the word.
- `sig_data` out 32: signature word.
- `sig_idx` out $clog2(SIG_WORDS) (min 1): index of `sig_data`.
- `sig_last` out 1: current word is index SIG_WORDS-1.
- `halted` out 1: end-of-test write seen.
- `timed_out` out 1: dump was forced by timeout.
- `exit_code` out 32: value written to `tohost`. Zero on timeout.
- `done` out 1: all words transferred.

## Operation
- States: RUN, DUMP, DONE. Reset (`rst_n`=0 at a rising edge) has these effects:
  - state becomes RUN and all shadow words are cleared to 0;
  - the timeout counter, `sig_idx` and `exit_code` are cleared to 0;
  - `sig_valid`, `sig_last`, `halted`, `timed_out` and `done` are driven to 0.
- Reset mid-dump aborts the transfer immediately, with no partial `sig_last`.
- Address decode uses word addresses `dmem_addr[31:2]`. Bits [1:0] are ignored.
- A store hits signature word k when `dmem_addr[31:2] - SIG_BASE[31:2]` = k and k < SIG_WORDS.
- RUN state:
  - A `dmem_we` hit on word k updates only the byte lanes whose strobe is 1.
  - Stores elsewhere are ignored.
  - The timeout counter increments every cycle.
- RUN to DUMP, on tohost: `dmem_we` with a word match on `TOHOST_ADDR`, full-word strobe 4'hF and `dmem_wdata` ≠ 0. Effects:
  - `exit_code` ← `dmem_wdata`;
  - `halted` ← 1.
  - `tohost` writes of zero or with partial strobes are ignored and stay in RUN.
- RUN to DUMP, on timeout (TIMEOUT_CYCLES ≠ 0): counter == TIMEOUT_CYCLES-1 with no qualifying tohost write that cycle. Effects:
  - `timed_out` ← 1;
  - `exit_code` stays 0;
  - `halted` stays 0.
- Simultaneous tohost write and timeout: tohost wins and `timed_out` stays 0.
- DUMP state:
  - The shadow is frozen and all stores are ignored.
  - `sig_valid`=1 and `sig_data`=shadow[`sig_idx`]; `sig_idx` starts at 0.
  - A transfer occurs when `sig_valid && sig_ready`. On transfer `sig_idx` increments.
  - `sig_last` = (`sig_idx` == SIG_WORDS-1).
  - While `sig_valid && !sig_ready`, `sig_data`, `sig_idx` and `sig_last` are held stable.
- DUMP to DONE: on the transfer with `sig_last`=1. Effects:
  - `sig_valid` ← 0 and `done` ← 1;
  - DONE is terminal until reset;
  - `halted`, `timed_out` and `exit_code` hold their values.
- `sig_valid` never depends combinationally on `sig_ready`.

## Timing
- Shadow write latency: 1 cycle. A store at edge N is visible in the shadow after edge N.
- Trigger latency: a qualifying tohost write sampled at edge N gives, from N+1:
  - `halted`=1;
  - `sig_valid`=1 with `sig_idx`=0.
- With `sig_ready` held high, word k transfers at edge N+1+k.
- `done`=1 after edge N+SIG_WORDS, so total dump time is SIG_WORDS cycles.
- Timeout: with no trigger, DUMP is entered at the edge where the counter reaches TIMEOUT_CYCLES-1. `sig_valid` rises TIMEOUT_CYCLES cycles after reset release.
- All outputs are registered except `sig_data`, a mux of registered shadow by registered `sig_idx`.

## Test plan
- Byte-strobe capture:
  - Stimulus: store 32'hDEADBEEF to 0x1004 (strb F), then 32'h000000AA to 0x1004 (strb 1), then tohost 1.
  - Required: the dump gives sig[1]=0xDEADBEAA and all other words 0.
- Normal dump, ready high:
  - Stimulus: write 0x100+i to words 0..7, then `tohost`=0x1 at edge N.
  - Required:
    - `halted`=1 and `sig_valid`=1 at N+1;
    - words 0x100..0x107 appear with idx 0..7;
    - `sig_last` only on idx 7;
    - `done`=1 after edge N+8 and `exit_code`=1.
- Backpressure:
  - Stimulus: hold `sig_ready`=0 for 3 cycles during idx 2, toggle it randomly afterwards.
  - Required: `sig_data`/`sig_idx` are stable while stalled and there are exactly 8 transfers in order.
- Ignored writes:
  - Stimulus:
    - `tohost`=0;
    - `tohost` with strb 4'h3;
    - store to 0x1020 (word 8, out of range);
    - store during DUMP.
  - Required: no trigger and no shadow change.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16 with no tohost.
  - Required:
    - `sig_valid` rises 16 cycles after reset release;
    - `timed_out`=1, `halted`=0, `exit_code`=0.
  - Then repeat with tohost=5 on the counter==15 cycle. Required: `halted`=1, `timed_out`=0, `exit_code`=5.
- Reset mid-dump:
  - Stimulus: assert `rst_n`=0 at idx 3.
  - Required: next edge all outputs 0 and shadow 0. A new tohost write then restarts the dump at idx 0 with all zero words.
